vga_timing_receiver: RTL and testbench

Sink-side counterpart to the VGA timing generator. It samples incoming hsync/vsync on the pixel clock and recovers the horizontal and vertical counts from the sync edges. It measures the line and frame periods and compares them against the expected mode. Once the timing is proven, it asserts lock and publishes the pixel coordinates and the active-video window. It feeds loopback self-test and downstream frame-capture logic.

---
 rtl/vga_timing_receiver.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// Recovers VGA line/frame timing from incoming sync pulses and, once the measured
// periods match the expected mode, publishes pixel coordinates and the active window.
module vga_timing_receiver #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int LOCK_LINES = 8
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_active,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [10:0] h_total_measured,
    output logic [9:0]  v_total_measured
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int GW      = $clog2(LOCK_LINES + 1);

    localparam logic [11:0]   H_TOTAL_C = 12'(H_TOTAL);
    localparam logic [10:0]   V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0]   H_START_C = 11'(H_START);
    localparam logic [10:0]   H_END_C   = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]    V_START_C = 10'(V_START);
    localparam logic [9:0]    V_END_C   = 10'(V_START + V_ACTIVE);
    localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_LINES);
    localparam logic          POL       = 1'(SYNC_POL);

    typedef enum logic [2:0] {SEARCH, TRACK, WAIT_V, VERIFY, LOCKED} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] good_cnt, good_nx;
    logic          err_nx;

    logic        hs_q, hs_q_d, vs_q, vs_q_d;
    logic        hs_edge, vs_edge;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [11:0] h_len;
    logic [10:0] v_len;
    logic        h_sat, line_ok, line_bad, frame_ok;
    logic        in_h, in_v;

    assign hs_edge  = (hs_q == POL) && (hs_q_d != POL);
    assign vs_edge  = (vs_q == POL) && (vs_q_d != POL);
    assign h_sat    = (h_cnt == 11'h7ff);
    assign h_len    = {1'b0, h_cnt} + 12'd1;
    // an hsync edge landing on the vsync edge closes the old frame, so count it here
    assign v_len    = {1'b0, v_cnt} + {10'd0, hs_edge};
    assign line_ok  = (h_len == H_TOTAL_C);
    assign line_bad = hs_edge && !line_ok;
    assign frame_ok = (v_len == V_TOTAL_C);

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            hs_q             <= !POL;
            hs_q_d           <= !POL;
            vs_q             <= !POL;
            vs_q_d           <= !POL;
            h_cnt            <= '0;
            v_cnt            <= '0;
            h_total_measured <= '0;
            v_total_measured <= '0;
        end else begin
            hs_q   <= hsync_in;
            hs_q_d <= hs_q;
            vs_q   <= vsync_in;
            vs_q_d <= vs_q;

            if (hs_edge) begin
                h_cnt            <= '0;
                h_total_measured <= h_len[11] ? 11'h7ff : h_len[10:0];
            end else if (!h_sat) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (vs_edge) begin
                v_cnt            <= '0;
                v_total_measured <= v_len[10] ? 10'h3ff : v_len[9:0];
            end else if (hs_edge && v_cnt != 10'h3ff) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state        <= SEARCH;
            good_cnt     <= '0;
            timing_error <= 1'b0;
        end else begin
            state        <= state_nx;
            good_cnt     <= good_nx;
            timing_error <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_nx   = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_edge) begin
                    state_nx = TRACK;
                    good_nx  = '0;
                end
            end
            TRACK: begin
                if (hs_edge) begin
                    if (line_ok) begin
                        good_nx = good_cnt + 1'b1;
                        if (good_nx == LOCK_C) state_nx = WAIT_V;
                    end else begin
                        good_nx = '0;
                    end
                end
            end
            WAIT_V: begin
                if (line_bad) begin
                    state_nx = TRACK;
                    good_nx  = '0;
                end else if (vs_edge) begin
                    state_nx = VERIFY;
                end
            end
            VERIFY: begin
                if (line_bad) begin
                    state_nx = TRACK;
                    good_nx  = '0;
                end else if (vs_edge && frame_ok) begin
                    state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || (vs_edge && !frame_ok)) begin
                    state_nx = TRACK;
                    good_nx  = '0;
                    err_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
                good_nx  = '0;
            end
        endcase
        // lost hsync; in SEARCH the counter stays pinned until the next edge restarts tracking
        if (h_sat && state != SEARCH) begin
            state_nx = SEARCH;
            good_nx  = '0;
            err_nx   = (state == LOCKED);
        end
    end

    assign locked       = (state == LOCKED);
    assign in_h         = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
    assign in_v         = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
    assign video_active = locked && in_h && in_v;
    assign pixel_x      = video_active ? 10'(h_cnt - H_START_C) : 10'd0;
    assign pixel_y      = video_active ? (v_cnt - V_START_C) : 10'd0;
    assign line_start   = hs_edge && locked;
    assign frame_start  = vs_edge && locked;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench: a reduced video mode keeps frames short; both sync polarities
// run side by side from one stimulus stream and are held to the same expectations.
module tb_vga_timing_receiver;

    localparam int HA = 40, HF = 4, HS = 8, HB = 8;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int LL = 8;
    localparam int HT = HA + HF + HS + HB;   // 60
    localparam int VT = VA + VF + VS + VB;   // 27
    localparam int HST = HS + HB;            // 16
    localparam int VST = VS + VB;            // 5

    localparam int S_VA = 0, S_PX = 1, S_PY = 2, S_LS = 3, S_FS = 4;
    localparam int S_LK = 5, S_TE = 6, S_HT = 7, S_VT = 8;
    localparam int LU = 1, LD = 2, TE = 4;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic reset;
    logic hs_a, vs_a;
    logic hs0, vs0, hs1, vs1;
    assign hs0 = ~hs_a;
    assign vs0 = ~vs_a;
    assign hs1 = hs_a;
    assign vs1 = vs_a;

    logic [9:0]  px [2];
    logic [9:0]  py [2];
    logic        va [2];
    logic        ls [2];
    logic        fs [2];
    logic        lk [2];
    logic        te [2];
    logic [10:0] ht [2];
    logic [9:0]  vt [2];

    vga_timing_receiver #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0), .LOCK_LINES(LL)) u_neg (
        .clk_25MHz(clk), .reset(reset), .hsync_in(hs0), .vsync_in(vs0),
        .pixel_x(px[0]), .pixel_y(py[0]), .video_active(va[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .locked(lk[0]), .timing_error(te[0]),
        .h_total_measured(ht[0]), .v_total_measured(vt[0]));

    vga_timing_receiver #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1), .LOCK_LINES(LL)) u_pos (
        .clk_25MHz(clk), .reset(reset), .hsync_in(hs1), .vsync_in(vs1),
        .pixel_x(px[1]), .pixel_y(py[1]), .video_active(va[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .locked(lk[1]), .timing_error(te[1]),
        .h_total_measured(ht[1]), .v_total_measured(vt[1]));

    typedef struct {int cyc; int mask;} ev_t;
    typedef struct {int cyc; int sig; int exp; string nm;} pr_t;
    ev_t evq[$];
    pr_t pq[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit lk_prev [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int getsig(input int d, input int s);
        case (s)
            S_VA:    return va[d] ? 1 : 0;
            S_PX:    return int'(px[d]);
            S_PY:    return int'(py[d]);
            S_LS:    return ls[d] ? 1 : 0;
            S_FS:    return fs[d] ? 1 : 0;
            S_LK:    return lk[d] ? 1 : 0;
            S_TE:    return te[d] ? 1 : 0;
            S_HT:    return int'(ht[d]);
            S_VT:    return int'(vt[d]);
            default: return -1;
        endcase
    endfunction

    task automatic push_ev(input int c, input int m);
        evq.push_back('{cyc: c, mask: m});
    endtask

    task automatic push_pr(input int c, input int s, input int e, input string n);
        pq.push_back('{cyc: c, sig: s, exp: e, nm: n});
    endtask

    task automatic push_zero(input int c, input string n);
        for (int s = S_VA; s <= S_VT; s++) push_pr(c, s, 0, n);
    endtask

    // Monitor: lock edges and error pulses must line up with queued events; probes sample fields.
    always @(negedge clk) begin : mon
        int em, om, v;
        if (mon_en) begin
            em = 0;
            for (int i = evq.size() - 1; i >= 0; i--)
                if (evq[i].cyc == cyc) begin
                    em = em | evq[i].mask;
                    evq.delete(i);
                end
            for (int d = 0; d < 2; d++) begin
                om = ((lk[d] && !lk_prev[d]) ? LU : 0) | ((!lk[d] && lk_prev[d]) ? LD : 0) |
                     (te[d] ? TE : 0);
                if (em != 0 || om != 0) begin
                    checks++;
                    if (om != em) begin
                        errors++;
                        $display("FAIL events pol%0d cyc %0d: got mask %0d, want %0d", d, cyc, om, em);
                    end
                end
            end
            for (int i = pq.size() - 1; i >= 0; i--)
                if (pq[i].cyc == cyc) begin
                    for (int d = 0; d < 2; d++) begin
                        checks++;
                        v = getsig(d, pq[i].sig);
                        if (v != pq[i].exp) begin
                            errors++;
                            $display("FAIL %s pol%0d cyc %0d sig %0d: got %0d, want %0d",
                                     pq[i].nm, d, cyc, pq[i].sig, v, pq[i].exp);
                        end
                    end
                    pq.delete(i);
                end
        end
        for (int d = 0; d < 2; d++) lk_prev[d] = lk[d];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives nl lines starting with vsync; one line may be a clock short.
    // With pix set, probes the active window assuming the receiver stays locked.
    task automatic frame(input int nl, input int short_l, input bit pix);
        int c0, len;
        c0 = cyc + 1;
        if (pix) begin
            push_pr(c0 + 5*HT + 2 + HST - 1,  S_VA, 0,      "va_before_start");
            push_pr(c0 + 5*HT + 2 + HST,      S_VA, 1,      "va_first");
            push_pr(c0 + 5*HT + 2 + HST,      S_PX, 0,      "px_first");
            push_pr(c0 + 5*HT + 2 + HST,      S_PY, 0,      "py_first");
            push_pr(c0 + 5*HT + 2 + HST+HA-1, S_PX, HA-1,   "px_last");
            push_pr(c0 + 5*HT + 2 + HST+HA-1, S_VA, 1,      "va_last");
            push_pr(c0 + 5*HT + 2 + HST+HA,   S_VA, 0,      "va_after_end");
            push_pr(c0 + 5*HT + 2 + HST+HA,   S_PX, 0,      "px_after_end");
            push_pr(c0 + (VST-1)*HT + 2 + HST, S_VA, 0,     "va_line_above");
            push_pr(c0 + (VST+VA-1)*HT + 2 + HST, S_PY, VA-1, "py_last");
            push_pr(c0 + (VST+VA)*HT + 2 + HST, S_VA, 0,    "va_line_below");
            push_pr(c0 + (VST+VA)*HT + 2 + HST, S_PY, 0,    "py_line_below");
            push_pr(c0 + 5*HT + 1,            S_LS, 1,      "line_start");
            push_pr(c0 + 5*HT + 2,            S_LS, 0,      "line_start_pulse");
            push_pr(c0 + 10*HT,               S_HT, HT,     "h_total");
            push_pr(c0 + 10*HT,               S_VT, VT,     "v_total");
        end
        for (int l = 0; l < nl; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                tick();
                hs_a = (p < HS);
                vs_a = (l < VS);
            end
        end
    endtask

    initial begin : stim
        int c, n;
        reset = 1'b1;
        hs_a  = 1'b0;
        vs_a  = 1'b0;
        repeat (3) tick();
        mon_en = 1'b1;
        push_zero(cyc, "reset_state");
        tick();
        reset = 1'b0;

        // acquisition on a compliant stream
        frame(VT, -1, 0);
        frame(VT, -1, 0);
        c = cyc + 1;
        push_ev(c + 2, LU);
        push_pr(c + 1, S_FS, 0, "fs_not_locked");
        push_pr(c + 1, S_LK, 0, "lk_before_lock");
        push_pr(c + 2, S_LK, 1, "lk_at_lock");
        frame(VT, -1, 1);
        c = cyc + 1;
        push_pr(c + 1, S_FS, 1, "frame_start");
        push_pr(c + 2, S_FS, 0, "frame_start_pulse");
        frame(VT, -1, 1);

        // one short line while locked
        c = cyc + 1;
        n = c + 11*HT - 1;
        push_pr(n + 1, S_LS, 1, "ls_on_bad_line");
        push_ev(n + 2, LD | TE);
        push_pr(n + 2, S_HT, HT - 1, "h_total_short");
        push_pr(n + 3, S_TE, 0, "te_single");
        frame(VT, 10, 0);
        frame(VT, -1, 0);
        c = cyc + 1;
        push_ev(c + 2, LU);
        frame(VT, -1, 1);

        // reset mid-frame while locked
        frame(12, -1, 0);
        c = cyc + 1;
        push_ev(c, LD);
        push_zero(c, "reset_mid_frame");
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        frame(VT, -1, 0);
        frame(VT, -1, 0);
        c = cyc + 1;
        push_ev(c + 2, LU);
        frame(VT, -1, 0);

        // hsync disappears while locked
        c = cyc + 1;
        n = c + 9*HT;
        push_pr(n + 2049, S_LK, 1, "lk_at_2047");
        push_ev(n + 2050, LD | TE);
        push_pr(n + 2051, S_TE, 0, "te_sat_single");
        push_pr(n + 2060, S_VA, 0, "va_after_sat");
        push_pr(n + 2060, S_LS, 0, "ls_after_sat");
        frame(10, -1, 0);
        repeat (2100) tick();

        // short frame in VERIFY must not lock
        frame(VT, -1, 0);
        frame(VT - 1, -1, 0);
        c = cyc + 1;
        push_pr(c + 2, S_LK, 0, "lk_bad_frame");
        push_pr(c + 2, S_VT, VT - 1, "v_total_short");
        frame(VT, -1, 0);
        c = cyc + 1;
        push_ev(c + 2, LU);
        push_pr(c + 2, S_VT, VT, "v_total_ok");
        frame(VT, -1, 1);
        repeat (5) tick();

        checks++;
        if (pq.size() != 0 || evq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d probes and %0d events pending, want 0", pq.size(), evq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #20_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
